// File: rtl/decodificador_pt2272.sv
`default_nettype none
// ============================================================================
// decodificador_pt2272 : PT2272-style receiver for a PT2262 trinary stream
// Rev 1.0
// ============================================================================
module decodificador_pt2272 #(
  parameter int ALPHA_CLKS     = 250,
  parameter int SYNC_MIN_ALPHA = 64,
  parameter int VT_HOLD_FRAMES = 4,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cod_i,
  input  logic [7:0] addr_val,
  input  logic [7:0] addr_f,
  output logic [3:0] d_o,
  output logic       vt,
  output logic       frame_ok,
  output logic       rx_err
);

  localparam logic [CNT_W-1:0] c_short_min = CNT_W'(2 * ALPHA_CLKS);
  localparam logic [CNT_W-1:0] c_long_min  = CNT_W'(8 * ALPHA_CLKS);
  localparam logic [CNT_W-1:0] c_long_max  = CNT_W'(16 * ALPHA_CLKS);
  localparam logic [CNT_W-1:0] c_sync_min  = CNT_W'(SYNC_MIN_ALPHA * ALPHA_CLKS);
  localparam int               c_hold_cyc  = VT_HOLD_FRAMES * 512 * ALPHA_CLKS;
  localparam int               c_hold_w    = (c_hold_cyc > 2) ? $clog2(c_hold_cyc) : 1;
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(c_hold_cyc - 1);
  localparam logic [1:0]       c_t0        = 2'b00;
  localparam logic [1:0]       c_t1        = 2'b01;
  localparam logic [1:0]       c_tf        = 2'b10;
  localparam logic [4:0]       c_sync_high = 5'd24;
  localparam logic [4:0]       c_all_highs = 5'd25;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_ARMED = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  logic                r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]    r_cnt;
  state_t              r_state, w_state_nxt;
  logic [4:0]          r_highs, w_highs_nxt;
  logic                r_first, w_first_nxt;
  logic [23:0]         r_bits, w_bits_nxt;
  logic [3:0]          r_cand;
  logic                r_cand_valid;
  logic [c_hold_w-1:0] r_hold;
  logic [3:0]          r_d;
  logic                r_vt, r_frame_ok, r_rx_err;

  logic       w_rise, w_fall, w_edge;
  logic       w_short, w_long, w_ok, w_sync;
  logic [1:0] w_trit;
  logic       w_trit_bad, w_err;
  logic       w_addr_ok, w_data_ok;
  logic [3:0] w_data;

  assign w_rise  = r_sync2 & ~r_prev;
  assign w_fall  = ~r_sync2 & r_prev;
  assign w_edge  = r_sync2 ^ r_prev;
  assign w_short = (r_cnt >= c_short_min) && (r_cnt < c_long_min);
  assign w_long  = (r_cnt >= c_long_min) && (r_cnt <= c_long_max);
  assign w_ok    = w_short | w_long;
  // Live sync detection: the low run qualifies as soon as it is long enough.
  assign w_sync  = ~r_sync2 && ~w_fall && (r_cnt >= c_sync_min);

  // Pair (first high, second high): S,S=0  L,L=1  S,L=F  L,S=invalid
  assign w_trit     = r_first ? c_t1 : (w_long ? c_tf : c_t0);
  assign w_trit_bad = r_first & ~w_long;

  always_comb begin
    w_state_nxt = r_state;
    w_highs_nxt = r_highs;
    w_first_nxt = r_first;
    w_bits_nxt  = r_bits;
    w_err       = 1'b0;
    case (r_state)
      S_HUNT: if (w_sync) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_highs_nxt = '0;
          w_bits_nxt  = '0;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          if (!w_ok || (r_highs == c_sync_high && w_long) ||
              (r_highs != c_sync_high && r_highs[0] && w_trit_bad)) begin
            w_err       = 1'b1;
            w_state_nxt = S_HUNT;
          end else begin
            w_highs_nxt = r_highs + 5'd1;
            w_state_nxt = S_LOW;
            if (r_highs != c_sync_high) begin
              if (!r_highs[0]) w_first_nxt = w_long;
              else w_bits_nxt[{r_highs[4:1], 1'b0} +: 2] = w_trit;
            end
          end
        end
      end
      S_LOW: begin
        if (w_rise) begin
          if (w_ok && r_highs < c_all_highs) begin
            w_state_nxt = S_HIGH;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_HUNT;
          end
        end else if (w_sync) begin
          if (r_highs == c_all_highs) begin
            w_state_nxt = S_CHECK;
          end else begin
            // A premature sync gap still marks the start of a new frame.
            w_err       = 1'b1;
            w_state_nxt = S_ARMED;
          end
        end
      end
      S_CHECK: w_state_nxt = S_ARMED;
      default: w_state_nxt = S_HUNT;
    endcase
  end

  always_comb begin
    w_addr_ok = 1'b1;
    w_data_ok = 1'b1;
    w_data    = '0;
    for (int i = 0; i < 8; i++) begin
      if (addr_f[i]) begin
        if (r_bits[2*i +: 2] != c_tf) w_addr_ok = 1'b0;
      end else if (r_bits[2*i +: 2] != {1'b0, addr_val[i]}) begin
        w_addr_ok = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      w_data[3-k] = r_bits[2*(8+k)];
      if (r_bits[2*(8+k) +: 2] == c_tf) w_data_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_cnt        <= '0;
      r_state      <= S_HUNT;
      r_highs      <= '0;
      r_first      <= 1'b0;
      r_bits       <= '0;
      r_cand       <= '0;
      r_cand_valid <= 1'b0;
      r_hold       <= '0;
      r_d          <= '0;
      r_vt         <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      r_sync1    <= cod_i;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_state    <= w_state_nxt;
      r_highs    <= w_highs_nxt;
      r_first    <= w_first_nxt;
      r_bits     <= w_bits_nxt;
      r_frame_ok <= 1'b0;
      r_rx_err   <= w_err;
      if (w_edge) r_cnt <= CNT_W'(1);
      else if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);

      if (r_vt) begin
        if (r_hold == '0) r_vt <= 1'b0;
        else r_hold <= r_hold - c_hold_w'(1);
      end

      // Acceptance is written after the hold logic so a reload beats expiry.
      if (r_state == S_CHECK) begin
        if (w_addr_ok && w_data_ok) begin
          if (r_cand_valid && r_cand == w_data) begin
            r_d        <= w_data;
            r_vt       <= 1'b1;
            r_frame_ok <= 1'b1;
            r_hold     <= c_hold_load;
          end else begin
            r_cand       <= w_data;
            r_cand_valid <= 1'b1;
          end
        end else begin
          r_cand       <= '0;
          r_cand_valid <= 1'b0;
        end
      end else if (w_err) begin
        r_cand       <= '0;
        r_cand_valid <= 1'b0;
      end
    end
  end

  assign d_o      = r_d;
  assign vt       = r_vt;
  assign frame_ok = r_frame_ok;
  assign rx_err   = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_pt2272.sv
`default_nettype none
// ============================================================================
// tb_decodificador_pt2272 : directed bench for the PT2272-style decoder
// Rev 1.0
// ============================================================================
module tb_decodificador_pt2272;

  localparam int A      = 4;
  localparam int SYNC_A = 64;
  localparam int HOLD_F = 4;
  // Cycles from the sync-low drive to the frame_ok cycle:
  // 2-FF sync + edge register, SYNC_A*A low run, CHECK state, output register.
  localparam int LAT    = SYNC_A * A + 4;
  localparam int HOLD   = HOLD_F * 512 * A;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cod_i = 1'b0;
  logic [7:0] addr_val = 8'h00;
  logic [7:0] addr_f = 8'h00;
  logic [3:0] d_o;
  logic       vt, frame_ok, rx_err;

  int n_tests = 0;
  int n_fail  = 0;
  int fok_cnt = 0;
  int err_cnt = 0;
  int base;

  logic [23:0] f;
  logic [23:0] fx;

  always #5 clk = ~clk;

  decodificador_pt2272 #(
    .ALPHA_CLKS(A), .SYNC_MIN_ALPHA(SYNC_A), .VT_HOLD_FRAMES(HOLD_F), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cod_i(cod_i), .addr_val(addr_val), .addr_f(addr_f),
    .d_o(d_o), .vt(vt), .frame_ok(frame_ok), .rx_err(rx_err)
  );

  always @(posedge clk) begin
    if (frame_ok === 1'b1) fok_cnt++;
    if (rx_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk_frame(input logic [7:0] av, input logic [7:0] af,
                                          input logic [3:0] d);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = af[i] ? 2'b10 : {1'b0, av[i]};
    for (int k = 0; k < 4; k++) r[2*(8+k) +: 2] = {1'b0, d[3-k]};
    return r;
  endfunction

  task automatic drive(input logic lvl, input int n);
    cod_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l, input bit glitch);
    drive(1'b1, h * A);
    if (glitch) begin
      drive(1'b0, 5 * A);
      drive(1'b1, A);
      drive(1'b0, (l - 6) * A);
    end else begin
      drive(1'b0, l * A);
    end
  endtask

  task automatic send_trit(input logic [1:0] t, input bit glitch);
    case (t)
      2'b00:   begin pulse(4, 12, glitch); pulse(4, 12, 1'b0); end
      2'b01:   begin pulse(12, 4, 1'b0);   pulse(12, 4, 1'b0); end
      default: begin pulse(4, 12, glitch); pulse(12, 4, 1'b0); end
    endcase
  endtask

  task automatic send_bits(input logic [23:0] fr, input int lo, input int hi, input int g);
    for (int i = lo; i <= hi; i++) send_trit(fr[2*i +: 2], i == g);
  endtask

  task automatic send_frame(input logic [23:0] fr);
    send_bits(fr, 0, 11, -1);
    drive(1'b1, 4 * A);
    drive(1'b0, 124 * A);
  endtask

  task automatic send_frame_chk(input logic [23:0] fr, input logic [3:0] exp_d);
    send_bits(fr, 0, 11, -1);
    drive(1'b1, 4 * A);
    drive(1'b0, LAT - 1);
    chk("fok_before", frame_ok, 0);
    @(negedge clk);
    chk("fok_pulse", frame_ok, 1);
    chk("d_o_accept", d_o, exp_d);
    chk("vt_accept", vt, 1);
    @(negedge clk);
    chk("fok_after", frame_ok, 0);
    drive(1'b0, 124 * A - LAT - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d_o", d_o, 0);
    chk("rst_vt", vt, 0);
    chk("rst_fok", frame_ok, 0);
    chk("rst_err", rx_err, 0);
    reset = 1'b0;

    // All-zero address, data 0xA: first frame only becomes the candidate
    drive(1'b0, 200 * A);
    f = mk_frame(8'h00, 8'h00, 4'hA);
    send_frame(f);
    chk("t1_first_vt", vt, 0);
    chk("t1_first_fok", fok_cnt, 0);
    send_frame_chk(f, 4'hA);
    chk("t1_fok_cnt", fok_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Floating address bits; a mismatching frame clears the candidate
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t2_rst_d_o", d_o, 0);
    chk("t2_rst_vt", vt, 0);
    addr_val = 8'h3C;
    addr_f   = 8'h81;
    drive(1'b0, 70 * A);
    f  = mk_frame(8'h3C, 8'h81, 4'h9);
    fx = mk_frame(8'h3C, 8'h80, 4'h9);
    send_frame(f);
    send_frame(fx);
    send_frame(f);
    chk("t2_mismatch_vt", vt, 0);
    chk("t2_mismatch_fok", fok_cnt, 1);
    send_frame_chk(f, 4'h9);
    chk("t2_err_cnt", err_cnt, 0);

    // Data changes need two consecutive identical frames
    base = fok_cnt;
    send_frame(mk_frame(8'h3C, 8'h81, 4'h5));
    send_frame_chk(mk_frame(8'h3C, 8'h81, 4'h5), 4'h5);
    send_frame(mk_frame(8'h3C, 8'h81, 4'h6));
    chk("t3_single6", d_o, 4'h5);
    send_frame(mk_frame(8'h3C, 8'h81, 4'h5));
    chk("t3_back5", d_o, 4'h5);
    send_frame(mk_frame(8'h3C, 8'h81, 4'h6));
    chk("t3_first6", d_o, 4'h5);
    send_frame_chk(mk_frame(8'h3C, 8'h81, 4'h6), 4'h6);
    chk("t3_fok_cnt", fok_cnt, base + 2);

    // Glitch at bit 5 drops the frame with a single rx_err
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    addr_val = 8'h00;
    addr_f   = 8'h00;
    drive(1'b0, 70 * A);
    f = mk_frame(8'h00, 8'h00, 4'h3);
    base = err_cnt;
    send_bits(f, 0, 11, 5);
    drive(1'b1, 4 * A);
    drive(1'b0, 124 * A);
    chk("t4_err_cnt", err_cnt, base + 1);
    chk("t4_glitch_vt", vt, 0);
    send_frame(f);
    chk("t4_cand_vt", vt, 0);

    // Second clean frame is accepted, then vt expires after the hold time
    send_bits(f, 0, 11, -1);
    drive(1'b1, 4 * A);
    drive(1'b0, LAT);
    chk("t5_fok", frame_ok, 1);
    chk("t5_vt", vt, 1);
    chk("t5_d_o", d_o, 4'h3);
    drive(1'b0, HOLD - 1);
    chk("t5_vt_last", vt, 1);
    @(negedge clk);
    chk("t5_vt_fall", vt, 0);
    chk("t5_d_o_hold", d_o, 4'h3);

    // Reset in the middle of a frame after an accept
    send_frame_chk(f, 4'h3);
    send_bits(f, 0, 5, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_d_o", d_o, 0);
    chk("t6_rst_vt", vt, 0);
    base = fok_cnt;
    send_bits(f, 6, 11, -1);
    drive(1'b1, 4 * A);
    drive(1'b0, 124 * A);
    chk("t6_no_fok", fok_cnt, base);
    chk("t6_d_o", d_o, 0);
    chk("t6_vt", vt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decodificador_pt2272.md
Name: decodificador_pt2272

Overview:
- Receiver stage directly downstream of the PT2262-style encoder; consumes its serial `cod_o` line.
- Measures high and low pulse widths against the 3 MHz `clk`, classifies each pulse as short (4α) or long (12α), and assembles the 12 trinary bits of a frame (A0..A7, then D3..D0).
- Validates the terminating sync bit and compares the address field with local trinary address inputs.
- Latches the 4 data bits and asserts `vt` only after two consecutive identical matching frames, as on the PT2272.

Parameters:
- ALPHA_CLKS, 250, `clk` cycles per oscillator period α (3 MHz / 12 kHz).
- SYNC_MIN_ALPHA, 64, minimum low run (in α) recognised as a sync gap.
- VT_HOLD_FRAMES, 4, frame times (1 frame = 512α) that `vt` stays high after the last accepted frame.
- CNT_W, 16, width of the pulse-width counter; saturates at all-ones.

Ports:
- clk  in  1  system clock, 3 MHz.
- reset  in  1  synchronous, active-high reset.
- cod_i  in  1  serial PT2262 stream, asynchronous to `clk`.
- addr_val  in  8  expected address bit values for A7..A0 (don't-care where `addr_f`=1).
- addr_f  in  8  per-bit F (floating) expectation; 1 = that address bit must be received as F.
- d_o  out  4  latched data D3..D0.
- vt  out  1  valid-transmission flag.
- frame_ok  out  1  one-cycle pulse per accepted frame.
- rx_err  out  1  one-cycle pulse on any protocol violation.

Behaviour:
- Reset state: `d_o`=0, `vt`=0, `frame_ok`=0, `rx_err`=0, FSM=HUNT, candidate cleared, counters 0.
- Input path: `cod_i` passes through a 2-FF synchroniser, then an edge detector; all widths are measured on the synchronised signal (2-cycle latency).
- Width counter: cleared on every edge, increments each `clk`, saturates at 2^CNT_W−1.
- Pulse class (w = width in `clk` cycles):
  - GLITCH: w < 2α.
  - SHORT: 2α ≤ w < 8α.
  - LONG: 8α ≤ w ≤ 16α.
  - OVER: w > 16α.
  - A low run is SYNC once w reaches SYNC_MIN_ALPHA·α. Detection is live at the threshold; no falling/rising edge is needed.
- FSM states:
  - HUNT: wait for a low run reaching SYNC; → ARMED. Line low after reset counts, so the encoder's first frame is accepted if the line was low ≥ SYNC_MIN before it.
  - ARMED: rising edge → HIGH, with bit index 0 and pulse index 0.
  - HIGH: measure until falling edge, then classify. SHORT/LONG are stored as the pulse symbol → LOW. GLITCH/OVER → rx_err, HUNT.
  - LOW: measure. On a rising edge with SHORT/LONG while fewer than 25 highs have been seen → HIGH. Every 2 highs form one bit:
    - S,S = 0
    - L,L = 1
    - S,L = F
    - L,S = invalid → rx_err, HUNT.
  - LOW (error exits): GLITCH, OVER-but-below-SYNC, or a SYNC reached before 25 highs → rx_err, HUNT. The SYNC case re-arms directly to ARMED instead of HUNT.
  - The 25th high must be SHORT (sync pulse); a LONG 25th high → rx_err.
  - When its following low reaches SYNC → CHECK.
  - CHECK (one cycle): address matches iff, for each i, (`addr_f`[i] and rx bit i is F) or (!`addr_f`[i] and rx bit i is 0/1 equal to `addr_val`[i]). F in a data bit is invalid. Then → ARMED, because the sync gap just seen arms the next frame.
- Acceptance:
  - On a match, if the candidate is valid and its data equal the received data: `d_o` ← data, `vt` ← 1, `frame_ok` pulse, and the hold counter reloads to VT_HOLD_FRAMES·512·α.
  - Otherwise the candidate ← received data (valid).
  - On mismatch, invalid data, or rx_err, the candidate is cleared. `vt`/`d_o` are unaffected.
  - All updates are registered: outputs change one cycle after the CHECK cycle.
- Hold: while `vt`=1 the counter decrements each `clk`; at 0, `vt` ← 0 and `d_o` holds its value. A hold counter of 20 bits is sufficient for defaults.
- Simultaneous: a reload in the same cycle as reaching 0 wins (`vt` stays 1).
- Reset mid-frame: all state discarded next cycle; a partial frame never updates `d_o`.

Test Plan:
- Line low 200α, then two frames A=all-0 (`addr_f`=0, `addr_val`=0x00), D=0xA → first frame: no `vt`. Second: `d_o`=0xA, `vt`=1, one `frame_ok`, exactly 1 cycle after the second CHECK.
- `addr_f`=0x81, `addr_val`=0x3C; frames with A0,A7=F and A6..A1=011110 → accepted. Same frames with A0=0 → `vt` stays 0, candidate cleared.
- Two matching frames with D=0x5, then D=0x6 once, then D=0x5 → `d_o` remains 0x5 throughout; D=0x6 sent twice → `d_o`=0x6.
- 1α high glitch injected at bit 5 → `rx_err` pulse, frame dropped; the next two clean frames → `vt`=1.
- Accept a frame, then hold the line low → `vt` falls exactly VT_HOLD_FRAMES·512·250 = 512000 cycles after the accept; `d_o` is unchanged.
- Assert `reset` mid-frame after an accepted frame → `d_o`=0, `vt`=0 next cycle; the remaining half-frame produces no `frame_ok`.
